// File: rtl/sn_reg_pkg.sv
// Shared constants and types for the sn_reg_file register block.
// Contents: address map, data/address widths, unmapped read value,
// scratch register index type and a scratch-range decode helper.
package sn_reg_pkg;

  localparam int unsigned ADDR_W      = 7;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned EV_W        = 4;
  localparam int unsigned TS_W        = 16;
  localparam int unsigned SCRATCH_NUM = 8;
  localparam int unsigned SCR_IDX_W   = 3;

  localparam logic [ADDR_W-1:0] ADDR_ID       = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_VERSION  = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_SCRATCH0 = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_SCRATCH7 = 7'h09;
  localparam logic [ADDR_W-1:0] ADDR_CTRL     = 7'h0A;
  localparam logic [ADDR_W-1:0] ADDR_STATUS   = 7'h0B;
  localparam logic [ADDR_W-1:0] ADDR_WR_COUNT = 7'h0C;
  localparam logic [ADDR_W-1:0] ADDR_TS_LO    = 7'h0D;
  localparam logic [ADDR_W-1:0] ADDR_TS_HI    = 7'h0E;
  localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK = 7'h0F;

  localparam logic [DATA_W-1:0] RD_UNMAPPED = 8'hEE;

  // Index into the scratch register array (address minus ADDR_SCRATCH0).
  typedef logic [SCR_IDX_W-1:0] scratch_idx_t;

  function automatic logic is_scratch(input logic [ADDR_W-1:0] addr);
    return (addr >= ADDR_SCRATCH0) && (addr <= ADDR_SCRATCH7);
  endfunction

  function automatic scratch_idx_t scratch_idx(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = addr - ADDR_SCRATCH0;
    return SCR_IDX_W'(off);
  endfunction

endpackage

// File: rtl/sn_reg_file.sv
// sn_reg_file: small control/status register block on a simple
// enable/r0w1 protocol with zero-latency combinational read data.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   prot_enable         qualifies prot_r0w1/prot_addr/prot_wdata
//   prot_r0w1           0 = read, 1 = write
//   prot_addr/wdata     register address / write data
//   prot_rdata          read data, combinational from prot_addr
//   hw_event            single-cycle event strobes into sticky bits
//   hw_level            live status levels shown in STATUS[7:4]
//   ctrl_start          one-cycle pulse after CTRL write with bit0 set
//   ctrl_mode           stored CTRL[7:1]
//   irq                 registered OR of (sticky AND mask)
module sn_reg_file
  import sn_reg_pkg::*;
#(
  parameter logic [7:0] P_ID_VALUE = 8'h5A,
  parameter logic [7:0] P_VERSION  = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       prot_enable,
  input  logic       prot_r0w1,
  input  logic [6:0] prot_addr,
  input  logic [7:0] prot_wdata,
  output logic [7:0] prot_rdata,
  input  logic [3:0] hw_event,
  input  logic [3:0] hw_level,
  output logic       ctrl_start,
  output logic [6:0] ctrl_mode,
  output logic       irq
);

  logic [DATA_W-1:0] scratch_q [SCRATCH_NUM];
  logic [DATA_W-1:0] scratch_d [SCRATCH_NUM];
  logic [6:0]        mode_q, mode_d;
  logic              start_q, start_d;
  logic [EV_W-1:0]   sticky_q, sticky_d;
  logic [EV_W-1:0]   mask_q, mask_d;
  logic              irq_q, irq_d;
  logic [DATA_W-1:0] wr_count_q, wr_count_d;
  logic [TS_W-1:0]   timer_q, timer_d;
  logic [TS_W-1:0]   snap_q, snap_d;
  logic [DATA_W-1:0] ts_hi_q, ts_hi_d;
  logic              en_prev_q, en_prev_d;
  logic              lo_rd_q, lo_rd_d;

  logic            wr_en;
  logic            rd_lo;
  logic            en_fall;
  logic [EV_W-1:0] sticky_clr;

  assign wr_en   = prot_enable & prot_r0w1;
  assign rd_lo   = prot_enable & ~prot_r0w1 & (prot_addr == ADDR_TS_LO);
  assign en_fall = en_prev_q & ~prot_enable;

  // Next-state logic for every register in the block.
  always_comb begin
    scratch_d  = scratch_q;
    mode_d     = mode_q;
    start_d    = 1'b0;
    mask_d     = mask_q;
    wr_count_d = wr_count_q;
    ts_hi_d    = ts_hi_q;
    lo_rd_d    = lo_rd_q;
    sticky_clr = '0;

    if (wr_en) begin
      if (wr_count_q != 8'hFF) begin
        wr_count_d = wr_count_q + 8'd1;
      end
      if (is_scratch(prot_addr)) begin
        scratch_d[scratch_idx(prot_addr)] = prot_wdata;
      end
      case (prot_addr)
        ADDR_CTRL: begin
          mode_d  = prot_wdata[7:1];
          start_d = prot_wdata[0];
        end
        ADDR_STATUS:   sticky_clr = prot_wdata[EV_W-1:0];
        ADDR_IRQ_MASK: mask_d     = prot_wdata[EV_W-1:0];
        default: ;
      endcase
    end

    // New events take priority over a simultaneous W1C clear.
    sticky_d = (sticky_q & ~sticky_clr) | hw_event;
    irq_d    = |(sticky_q & mask_q);

    timer_d   = timer_q + 16'd1;
    snap_d    = prot_enable ? snap_q : timer_q;
    en_prev_d = prot_enable;

    // Latch the high byte of the frozen snapshot once the access that read
    // TS_LO ends, so a later TS_HI read pairs with that TS_LO.
    if (en_fall) begin
      if (lo_rd_q) begin
        ts_hi_d = snap_q[15:8];
      end
      lo_rd_d = 1'b0;
    end
    if (rd_lo) begin
      lo_rd_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scratch_q  <= '{default: '0};
      mode_q     <= '0;
      start_q    <= 1'b0;
      sticky_q   <= '0;
      mask_q     <= '0;
      irq_q      <= 1'b0;
      wr_count_q <= '0;
      timer_q    <= '0;
      snap_q     <= '0;
      ts_hi_q    <= '0;
      en_prev_q  <= 1'b0;
      lo_rd_q    <= 1'b0;
    end else begin
      scratch_q  <= scratch_d;
      mode_q     <= mode_d;
      start_q    <= start_d;
      sticky_q   <= sticky_d;
      mask_q     <= mask_d;
      irq_q      <= irq_d;
      wr_count_q <= wr_count_d;
      timer_q    <= timer_d;
      snap_q     <= snap_d;
      ts_hi_q    <= ts_hi_d;
      en_prev_q  <= en_prev_d;
      lo_rd_q    <= lo_rd_d;
    end
  end

  // Read mux: driven from prot_addr whether or not prot_enable is high.
  always_comb begin
    prot_rdata = RD_UNMAPPED;
    if (is_scratch(prot_addr)) begin
      prot_rdata = scratch_q[scratch_idx(prot_addr)];
    end else begin
      case (prot_addr)
        ADDR_ID:       prot_rdata = P_ID_VALUE;
        ADDR_VERSION:  prot_rdata = P_VERSION;
        ADDR_CTRL:     prot_rdata = {mode_q, 1'b0};
        ADDR_STATUS:   prot_rdata = {hw_level, sticky_q};
        ADDR_WR_COUNT: prot_rdata = wr_count_q;
        ADDR_TS_LO:    prot_rdata = snap_q[7:0];
        ADDR_TS_HI:    prot_rdata = ts_hi_q;
        ADDR_IRQ_MASK: prot_rdata = {4'h0, mask_q};
        default:       prot_rdata = RD_UNMAPPED;
      endcase
    end
  end

  assign ctrl_start = start_q;
  assign ctrl_mode  = mode_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_sn_reg_file.sv
// Randomised + directed bench for sn_reg_file with a behavioural model and
// a read-data scoreboard.
module tb_sn_reg_file;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       prot_enable = 1'b0;
  logic       prot_r0w1 = 1'b0;
  logic [6:0] prot_addr = '0;
  logic [7:0] prot_wdata = '0;
  logic [7:0] prot_rdata;
  logic [3:0] hw_event = '0;
  logic [3:0] hw_level = '0;
  logic       ctrl_start;
  logic [6:0] ctrl_mode;
  logic       irq;

  always #5 clk = ~clk;

  sn_reg_file dut (
    .clk        (clk),
    .rst        (rst),
    .prot_enable(prot_enable),
    .prot_r0w1  (prot_r0w1),
    .prot_addr  (prot_addr),
    .prot_wdata (prot_wdata),
    .prot_rdata (prot_rdata),
    .hw_event   (hw_event),
    .hw_level   (hw_level),
    .ctrl_start (ctrl_start),
    .ctrl_mode  (ctrl_mode),
    .irq        (irq)
  );

  int total = 0;
  int bad = 0;
  bit mon_on = 1'b0;

  logic [7:0] exp_q[$];
  string      name_q[$];

  // Behavioural model state (plain integers and arrays).
  logic [7:0] m_scr [8];
  int m_mode, m_sticky, m_mask, m_wrc, m_timer, m_snap, m_tshi;
  bit m_start, m_irq, m_prev_en, m_lo_rd;

  function automatic void chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, act, exp, $time);
    end
  endfunction

  function automatic logic [7:0] m_read(input int a, input int lv);
    if (a >= 2 && a <= 9) return m_scr[a-2];
    case (a)
      0:  return 8'h5A;
      1:  return 8'h01;
      10: return 8'(m_mode * 2);
      11: return 8'(lv * 16 + m_sticky);
      12: return 8'(m_wrc);
      13: return 8'(m_snap % 256);
      14: return 8'(m_tshi);
      15: return 8'(m_mask);
      default: return 8'hEE;
    endcase
  endfunction

  // Reference model: advances on each clock from the inputs held that cycle.
  always @(posedge clk) begin
    int a;
    int clr;
    bit wr;
    a  = int'(prot_addr);
    wr = prot_enable && prot_r0w1;
    if (rst) begin
      for (int i = 0; i < 8; i++) m_scr[i] = 8'h00;
      m_mode = 0; m_sticky = 0; m_mask = 0; m_wrc = 0; m_timer = 0;
      m_snap = 0; m_tshi = 0; m_start = 0; m_irq = 0; m_prev_en = 0; m_lo_rd = 0;
    end else begin
      m_irq   = (m_sticky & m_mask) != 0;
      m_start = wr && a == 10 && prot_wdata[0];
      clr = 0;
      if (wr) begin
        if (a >= 2 && a <= 9) m_scr[a-2] = prot_wdata;
        if (a == 10) m_mode = int'(prot_wdata) / 2;
        if (a == 11) clr = int'(prot_wdata) % 16;
        if (a == 15) m_mask = int'(prot_wdata) % 16;
        m_wrc = (m_wrc < 255) ? m_wrc + 1 : 255;
      end
      m_sticky = (m_sticky & ~clr) | int'(hw_event);
      if (m_prev_en && !prot_enable) begin
        if (m_lo_rd) m_tshi = m_snap / 256;
        m_lo_rd = 0;
      end
      if (prot_enable && !prot_r0w1 && a == 13) m_lo_rd = 1;
      if (!prot_enable) m_snap = m_timer;
      m_timer   = (m_timer + 1) % 65536;
      m_prev_en = prot_enable;
    end
  end

  // Monitor: checks registered outputs every cycle, read data from the queue.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("ctrl_start", int'(ctrl_start), int'(m_start));
      chk("ctrl_mode", int'(ctrl_mode), m_mode);
      chk("irq", int'(irq), int'(m_irq));
      if (prot_enable && !prot_r0w1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rd_unexpected: got 0x%0h expected no read", prot_rdata);
        end else begin
          logic [7:0] e;
          string      n;
          e = exp_q.pop_front();
          n = name_q.pop_front();
          chk(n, int'(prot_rdata), int'(e));
        end
      end
    end
  end

  task automatic cyc(input bit en, input bit rw, input int a, input int d,
                     input int ev = 0, input bit r = 0);
    @(posedge clk);
    #1;
    rst         = r;
    prot_enable = en;
    prot_r0w1   = rw;
    prot_addr   = 7'(a);
    prot_wdata  = 8'(d);
    hw_event    = 4'(ev);
    if ($urandom_range(0, 3) == 0) hw_level = 4'($urandom);
    if (en && !rw) begin
      exp_q.push_back(m_read(a, int'(hw_level)));
      name_q.push_back($sformatf("rd_%02h", a));
    end
  endtask

  task automatic wr(input int a, input int d, input int ev = 0);
    cyc(1'b1, 1'b1, a, d, ev);
  endtask

  task automatic rd(input int a);
    cyc(1'b1, 1'b0, a, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_on = 1'b1;

    // Reset values of every readable register.
    for (int a = 0; a < 16; a++) rd(a);
    idle(1);

    // Scratch write/read and write counter.
    wr(5, 8'h3C);
    rd(5);
    rd(12);
    idle(1);

    // CTRL: start pulse, mode field, bit0 reads zero.
    wr(10, 8'h8B);
    idle(3);
    rd(10);
    idle(1);

    // Sticky events, mask, irq and set-wins-over-clear.
    wr(15, 8'h04);
    cyc(1'b0, 1'b0, 0, 0, 4'b0101);
    idle(3);
    rd(11);
    wr(11, 8'h04, 4'b0100);
    idle(1);
    rd(11);
    wr(11, 8'h01);
    idle(2);
    rd(11);
    idle(1);

    // Coherent timestamp across the 0x00FF -> 0x0100 carry.
    for (int i = 0; i < 400 && m_timer < 16'h00F4; i++) idle(1);
    for (int i = 0; i < 20; i++) rd(13);
    idle(1);
    rd(14);
    rd(13);
    idle(2);

    // Write counter saturation, unmapped read, write to read-only ID.
    for (int i = 0; i < 300; i++) wr(2 + (i % 8), int'($urandom_range(0, 255)));
    rd(12);
    rd(8'h40);
    wr(0, 8'h11);
    rd(0);
    idle(1);

    // Reset in the middle of a write.
    wr(2, 8'h11);
    wr(10, 8'hFF);
    wr(15, 8'h0F);
    cyc(1'b0, 1'b0, 0, 0, 4'hF);
    idle(2);
    cyc(1'b1, 1'b1, 2, 8'h77, 0, 1'b1);
    idle(1);
    rd(2);
    rd(10);
    rd(11);
    rd(12);
    rd(15);
    idle(1);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      bit en, rw, r;
      int a, ev;
      en = $urandom_range(0, 9) < 7;
      rw = $urandom_range(0, 1) == 1;
      a  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 127))
                                       : int'($urandom_range(0, 15));
      ev = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : 0;
      r  = $urandom_range(0, 299) == 0;
      cyc(en, rw, a, int'($urandom_range(0, 255)), ev, r);
    end
    idle(3);

    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sn_reg_file.md
SN_REG_FILE -- requirements
Module: sn_reg_file

Interface
REQ-001 SHALL have parameter P_ID_VALUE, default 8'h5A, the constant returned at address 0x00.
REQ-002 SHALL have parameter P_VERSION, default 8'h01, the constant returned at address 0x01.
REQ-003 SHALL have port clk, input, 1, the single clock; one clock, all state on posedge clk.
REQ-004 SHALL have port rst, input, 1, the reset; synchronous, active-high.
REQ-005 SHALL have port prot_enable, input, 1, qualifies all prot_* inputs.
REQ-006 SHALL have port prot_r0w1, input, 1, 0=read, 1=write.
REQ-007 SHALL have port prot_addr, input, 7, register address.
REQ-008 SHALL have port prot_wdata, input, 8, write data.
REQ-009 SHALL have port prot_rdata, output, 8, read data, combinational from prot_addr, zero read latency.
REQ-010 SHALL have port hw_event, input, 4, single-cycle event strobes.
REQ-011 SHALL have port hw_level, input, 4, live status levels.
REQ-012 SHALL have port ctrl_start, output, 1, one-cycle start pulse.
REQ-013 SHALL have port ctrl_mode, output, 7, stored mode field.
REQ-014 SHALL have port irq, output, 1, registered interrupt, equal to OR of (sticky AND mask).

Function
REQ-015 The address map SHALL be:
- 0x00 ID (RO)
- 0x01 VERSION (RO)
- 0x02-0x09 SCRATCH0-7 (RW, 8 bits)
- 0x0A CTRL: bit0 W1P start, bits[7:1] mode RW
- 0x0B STATUS: [3:0] sticky W1C, [7:4] hw_level live
- 0x0C WR_COUNT (RO)
- 0x0D TS_LO (RO)
- 0x0E TS_HI (RO)
- 0x0F IRQ_MASK (RW, [3:0]; [7:4] read 0)
REQ-016 A write SHALL occur on every cycle with prot_enable=1 and prot_r0w1=1; writes to RO or unmapped addresses SHALL have no effect except WR_COUNT.
REQ-017 Reads of unmapped addresses (0x10-0x7F) SHALL return 8'hEE; prot_rdata SHALL be driven from prot_addr regardless of prot_enable.
REQ-018 A write to CTRL with wdata[0]=1 SHALL assert ctrl_start for exactly the next cycle; CTRL bit0 SHALL read 0.
REQ-019 Sticky bit i SHALL set on the cycle after hw_event[i]=1 and clear on a STATUS write with wdata[i]=1; when both occur in the same cycle, set SHALL win.
REQ-020 WR_COUNT SHALL increment on each write cycle and saturate at 8'hFF.
REQ-021 A free-running 16-bit timer SHALL increment every cycle and wrap from 16'hFFFF to 0.
REQ-022 A 16-bit snapshot SHALL load the timer every cycle while prot_enable=0 and SHALL hold while prot_enable=1; TS_LO SHALL return snapshot[7:0].
REQ-023 On the falling edge of prot_enable after a read of 0x0D, snapshot[15:8] SHALL be copied into TS_HI, so that TS_LO followed by TS_HI gives a coherent 16-bit value.
REQ-024 prot_rdata SHALL remain stable for the whole of a multi-cycle read with prot_enable held high, unless hw_level or the sticky bits change.
REQ-025 irq SHALL update one cycle after any change to the sticky bits or IRQ_MASK.

Reset
REQ-026 On rst, SHALL clear: scratch, ctrl_mode, ctrl_start, sticky, WR_COUNT, timer, snapshot, TS_HI, IRQ_MASK and irq.
REQ-027 A reset asserted mid-access SHALL abort the access with no write effect, and the outputs SHALL be at their reset values on the next cycle.

Structure
REQ-028 The address constants, the unmapped read value 8'hEE, and the register-index typedef SHALL live in package sn_reg_pkg.
REQ-029 The design SHALL be a single module with no sub-modules; the timer and snapshot logic SHALL be kept in-module.

Verification
REQ-030 Write 0x3C to 0x05, then read 0x05 -> rdata=0x3C; WR_COUNT=1.
REQ-031 Write 0x8B to 0x0A -> ctrl_start high for exactly 1 cycle; ctrl_mode=0x45; read 0x0A -> 0x8A.
REQ-032 Pulse hw_event=4'b0101 with IRQ_MASK=0x04 -> irq=1; write 0x04 to 0x0B in the same cycle as a new hw_event[2] -> bit2 stays set.
REQ-033 Perform 300 writes -> WR_COUNT=0xFF; read 0x40 -> 0xEE; write to 0x00 -> ID remains 0x5A.
REQ-034 Read 0x0D for 20 cycles with the timer near 0x00FF -> TS_LO constant; then read 0x0E -> the high byte matches the same snapshot.
REQ-035 Assert rst during a write cycle to 0x02 -> SCRATCH0=0, and every output at reset value next cycle.
